// File: rtl/mem_channel_arbiter_if.sv
// Bundle of consumer-side request/response lines and memory-channel lines for the arbiter.
// master = arbiter view (serves consumers, drives memory channels); slave = environment view.
// No storage here; timing and backpressure are defined by the arbiter itself.
interface mem_channel_arbiter_if #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
);
  // consumer side
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  // memory channel side
  logic [NUM_CHANNELS-1:0]                 mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Round-robin share of NUM_CHANNELS memory channels among NUM_CONSUMERS load/store requesters.
// Latency: grant cycle, then mem valid next cycle; consumer ready the cycle after mem ready (>=3 cycles).
// Backpressure: mem valid held until mem ready; consumer ready held until the consumer drops its valid.
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input logic                   clk,
  input logic                   reset,
  mem_channel_arbiter_if.master bus
);

  localparam int NC  = NUM_CONSUMERS;
  localparam int NCH = NUM_CHANNELS;
  localparam int PW  = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } ch_state_e;

  ch_state_e            state_q [NCH];
  ch_state_e            state_d [NCH];
  logic [PW-1:0]        owner_q [NCH];
  logic [PW-1:0]        owner_d [NCH];
  logic [ADDR_BITS-1:0] addr_q  [NCH];
  logic [ADDR_BITS-1:0] addr_d  [NCH];
  logic [DATA_BITS-1:0] wdata_q [NCH];
  logic [DATA_BITS-1:0] wdata_d [NCH];
  logic [DATA_BITS-1:0] rdata_q [NCH];
  logic [DATA_BITS-1:0] rdata_d [NCH];
  logic [NC-1:0]        claim_q, claim_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

  // Scratch for the arbitration scan.
  logic [NC-1:0]        taken;
  logic [PW:0]          idx;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        last_sel;
  logic                 found;
  logic                 any_grant;

  // Per-channel next state, round-robin grant and claim bookkeeping.
  always_comb begin
    claim_d   = claim_q;
    rr_ptr_d  = rr_ptr_q;
    // A claim released this cycle stays blocked until next cycle, so scan against the registered claims.
    taken     = claim_q;
    idx       = '0;
    sel       = '0;
    last_sel  = '0;
    found     = 1'b0;
    any_grant = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      owner_d[ch] = owner_q[ch];
      addr_d[ch]  = addr_q[ch];
      wdata_d[ch] = wdata_q[ch];
      rdata_d[ch] = rdata_q[ch];
    end

    // Lower-index channels pick first; their grants are visible to higher channels via 'taken'.
    for (int ch = 0; ch < NCH; ch++) begin
      case (state_q[ch])
        IDLE: begin
          found = 1'b0;
          sel   = '0;
          for (int i = 0; i < NC; i++) begin
            idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NC)) idx = idx - (PW+1)'(NC);
            if (!found && !taken[idx[PW-1:0]] &&
                (bus.consumer_read_valid[idx[PW-1:0]] || bus.consumer_write_valid[idx[PW-1:0]])) begin
              found = 1'b1;
              sel   = idx[PW-1:0];
            end
          end
          if (found) begin
            taken[sel]   = 1'b1;
            claim_d[sel] = 1'b1;
            owner_d[ch]  = sel;
            any_grant    = 1'b1;
            last_sel     = sel;
            if (bus.consumer_read_valid[sel]) begin
              state_d[ch] = READ_WAIT;
              addr_d[ch]  = bus.consumer_read_address[sel];
            end else begin
              state_d[ch] = WRITE_WAIT;
              addr_d[ch]  = bus.consumer_write_address[sel];
              wdata_d[ch] = bus.consumer_write_data[sel];
            end
          end
        end
        READ_WAIT: begin
          if (bus.mem_read_ready[ch]) begin
            rdata_d[ch] = bus.mem_read_data[ch];
            state_d[ch] = READ_RELAY;
          end
        end
        WRITE_WAIT: begin
          if (bus.mem_write_ready[ch]) state_d[ch] = WRITE_RELAY;
        end
        READ_RELAY: begin
          if (!bus.consumer_read_valid[owner_q[ch]]) begin
            state_d[ch]          = IDLE;
            claim_d[owner_q[ch]] = 1'b0;
          end
        end
        WRITE_RELAY: begin
          if (!bus.consumer_write_valid[owner_q[ch]]) begin
            state_d[ch]          = IDLE;
            claim_d[owner_q[ch]] = 1'b0;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end

    if (any_grant) begin
      rr_ptr_d = (last_sel == PW'(NC - 1)) ? '0 : last_sel + PW'(1);
    end
  end

  // State registers; synchronous reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
        addr_q[ch]  <= '0;
        wdata_q[ch] <= '0;
        rdata_q[ch] <= '0;
      end
      claim_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        owner_q[ch] <= owner_d[ch];
        addr_q[ch]  <= addr_d[ch];
        wdata_q[ch] <= wdata_d[ch];
        rdata_q[ch] <= rdata_d[ch];
      end
      claim_q  <= claim_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  logic [NC-1:0]                consumer_read_ready;
  logic [NC-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NC-1:0]                consumer_write_ready;
  logic [NCH-1:0]               mem_read_valid;
  logic [NCH-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NCH-1:0]               mem_write_valid;
  logic [NCH-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NCH-1:0][DATA_BITS-1:0] mem_write_data;

  // Outputs decode purely from registered state; idle fields read as zero.
  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    mem_read_valid       = '0;
    mem_read_address     = '0;
    mem_write_valid      = '0;
    mem_write_address    = '0;
    mem_write_data       = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (state_q[ch] == READ_WAIT) begin
        mem_read_valid[ch]   = 1'b1;
        mem_read_address[ch] = addr_q[ch];
      end
      if (state_q[ch] == WRITE_WAIT) begin
        mem_write_valid[ch]   = 1'b1;
        mem_write_address[ch] = addr_q[ch];
        mem_write_data[ch]    = wdata_q[ch];
      end
      for (int c = 0; c < NC; c++) begin
        if (owner_q[ch] == PW'(c)) begin
          if (state_q[ch] == READ_RELAY) begin
            consumer_read_ready[c] = 1'b1;
            consumer_read_data[c]  = rdata_q[ch];
          end
          if (state_q[ch] == WRITE_RELAY) consumer_write_ready[c] = 1'b1;
        end
      end
    end
  end

  assign bus.consumer_read_ready  = consumer_read_ready;
  assign bus.consumer_read_data   = consumer_read_data;
  assign bus.consumer_write_ready = consumer_write_ready;
  assign bus.mem_read_valid       = mem_read_valid;
  assign bus.mem_read_address     = mem_read_address;
  assign bus.mem_write_valid      = mem_write_valid;
  assign bus.mem_write_address    = mem_write_address;
  assign bus.mem_write_data       = mem_write_data;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: one single-channel and one dual-channel instance.
// Inputs driven 1 time unit after posedge, outputs sampled there too.
// Expected values are hand-derived per scenario.
module tb_mem_channel_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_channel_arbiter_if #(.ADDR_BITS(32), .DATA_BITS(32), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) bus1 ();
  mem_channel_arbiter_if #(.ADDR_BITS(32), .DATA_BITS(32), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) bus2 ();

  mem_channel_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  mem_channel_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus1.consumer_read_valid    = '0;
    bus1.consumer_read_address  = '0;
    bus1.consumer_write_valid   = '0;
    bus1.consumer_write_address = '0;
    bus1.consumer_write_data    = '0;
    bus1.mem_read_ready         = '0;
    bus1.mem_read_data          = '0;
    bus1.mem_write_ready        = '0;
    bus2.consumer_read_valid    = '0;
    bus2.consumer_read_address  = '0;
    bus2.consumer_write_valid   = '0;
    bus2.consumer_write_address = '0;
    bus2.consumer_write_data    = '0;
    bus2.mem_read_ready         = '0;
    bus2.mem_read_data          = '0;
    bus2.mem_write_ready        = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Single-channel read: wait for issue, check address, answer, check relay and release.
  task automatic serve_read(input int c, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    while (!bus1.mem_read_valid[0] && n < 20) begin
      tick();
      n++;
    end
    check("rd_issue", 64'(bus1.mem_read_valid[0]), 64'd1);
    check("rd_addr", 64'(bus1.mem_read_address[0]), 64'(addr));
    bus1.mem_read_ready[0] = 1'b1;
    bus1.mem_read_data[0]  = data;
    tick();
    bus1.mem_read_ready[0] = 1'b0;
    check("rd_valid_drop", 64'(bus1.mem_read_valid[0]), 64'd0);
    check("rd_ready", 64'(bus1.consumer_read_ready), 64'(4'b0001 << c));
    check("rd_data", 64'(bus1.consumer_read_data[c]), 64'(data));
    bus1.consumer_read_valid[c] = 1'b0;
    tick();
    check("rd_release", 64'(bus1.consumer_read_ready), 64'd0);
  endtask

  task automatic serve_write(input int c, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    while (!bus1.mem_write_valid[0] && n < 20) begin
      tick();
      n++;
    end
    check("wr_issue", {bus1.mem_write_valid[0], bus1.mem_read_valid[0]}, 64'b10);
    check("wr_addr_data", {bus1.mem_write_address[0], bus1.mem_write_data[0]}, {addr, data});
    bus1.mem_write_ready[0] = 1'b1;
    tick();
    bus1.mem_write_ready[0] = 1'b0;
    check("wr_valid_drop", 64'(bus1.mem_write_valid[0]), 64'd0);
    check("wr_ready", 64'(bus1.consumer_write_ready), 64'(4'b0001 << c));
    bus1.consumer_write_valid[c] = 1'b0;
    tick();
    check("wr_release", 64'(bus1.consumer_write_ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;

    // Reset state.
    do_reset();
    check("rst_mem1", {bus1.mem_read_valid, bus1.mem_write_valid}, 64'd0);
    check("rst_cons1", {bus1.consumer_read_ready, bus1.consumer_write_ready}, 64'd0);
    check("rst_mem2", {bus2.mem_read_valid, bus2.mem_write_valid}, 64'd0);

    // Single read with memory answering after 3 cycles of valid.
    bus1.consumer_read_valid[0]   = 1'b1;
    bus1.consumer_read_address[0] = 32'h10;
    check("t1_no_early", 64'(bus1.mem_read_valid[0]), 64'd0);
    tick();
    check("t1_issue", {bus1.mem_read_valid[0], bus1.mem_read_address[0]}, {1'b1, 32'h10});
    tick();
    check("t1_hold1", {bus1.mem_read_valid[0], bus1.consumer_read_ready}, {1'b1, 4'b0000});
    tick();
    check("t1_hold2", {bus1.mem_read_valid[0], bus1.mem_read_address[0]}, {1'b1, 32'h10});
    bus1.mem_read_ready[0] = 1'b1;
    bus1.mem_read_data[0]  = 32'hDEAD;
    tick();
    bus1.mem_read_ready[0] = 1'b0;
    bus1.mem_read_data[0]  = 32'h0;
    check("t1_ready", {bus1.mem_read_valid[0], bus1.consumer_read_ready}, {1'b0, 4'b0001});
    check("t1_data", 64'(bus1.consumer_read_data[0]), 64'hDEAD);
    tick();
    tick();
    check("t1_held", {bus1.mem_read_valid[0], bus1.consumer_read_ready, bus1.consumer_read_data[0]},
          {1'b0, 4'b0001, 32'hDEAD});
    bus1.consumer_read_valid[0] = 1'b0;
    tick();
    check("t1_drop", 64'(bus1.consumer_read_ready), 64'd0);
    tick();
    tick();
    check("t1_no_reissue", 64'(bus1.mem_read_valid[0]), 64'd0);

    // Round-robin order from a fresh pointer, then wrap-around fairness.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus1.consumer_read_valid[c]   = 1'b1;
      bus1.consumer_read_address[c] = 32'h100 + 32'(c) * 32'h10;
    end
    serve_read(0, 32'h100, 32'hA0);
    serve_read(1, 32'h110, 32'hA1);
    serve_read(2, 32'h120, 32'hA2);
    bus1.consumer_read_valid[0]   = 1'b1;
    bus1.consumer_read_valid[3]   = 1'b1;
    bus1.consumer_read_address[3] = 32'h130;
    serve_read(3, 32'h130, 32'hA3);
    serve_read(0, 32'h100, 32'hB0);

    // Same consumer reads and writes together: read first, write after read relay.
    do_reset();
    bus1.consumer_read_valid[1]    = 1'b1;
    bus1.consumer_read_address[1]  = 32'h20;
    bus1.consumer_write_valid[1]   = 1'b1;
    bus1.consumer_write_address[1] = 32'h24;
    bus1.consumer_write_data[1]    = 32'h5;
    tick();
    check("t3_read_first", {bus1.mem_read_valid[0], bus1.mem_write_valid[0]}, 64'b10);
    serve_read(1, 32'h20, 32'h77);
    serve_write(1, 32'h24, 32'h5);

    // Two channels, four readers.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus2.consumer_read_valid[c]   = 1'b1;
      bus2.consumer_read_address[c] = 32'h200 + 32'(c) * 32'h10;
    end
    tick();
    check("t4_grant", {bus2.mem_read_valid, bus2.mem_read_address[0], bus2.mem_read_address[1]},
          {2'b11, 32'h200, 32'h210});
    bus2.mem_read_ready[0] = 1'b1;
    bus2.mem_read_data[0]  = 32'hA0;
    tick();
    bus2.mem_read_ready[0] = 1'b0;
    check("t4_c0_ready", {bus2.consumer_read_ready, bus2.consumer_read_data[0]}, {4'b0001, 32'hA0});
    bus2.consumer_read_valid[0] = 1'b0;
    tick();
    check("t4_c0_release", {bus2.consumer_read_ready, bus2.mem_read_valid}, {4'b0000, 2'b10});
    tick();
    check("t4_c2_grant", {bus2.mem_read_valid, bus2.mem_read_address[0], bus2.mem_read_address[1]},
          {2'b11, 32'h220, 32'h210});
    bus2.mem_read_ready[1] = 1'b1;
    bus2.mem_read_data[1]  = 32'hB1;
    tick();
    bus2.mem_read_ready[1] = 1'b0;
    check("t4_c1_ready", {bus2.consumer_read_ready, bus2.consumer_read_data[1]}, {4'b0010, 32'hB1});
    bus2.consumer_read_valid[1] = 1'b0;
    tick();
    tick();
    check("t4_c3_grant", {bus2.mem_read_valid, bus2.mem_read_address[0], bus2.mem_read_address[1]},
          {2'b11, 32'h220, 32'h230});
    bus2.mem_read_ready = 2'b11;
    bus2.mem_read_data[0] = 32'hC2;
    bus2.mem_read_data[1] = 32'hD3;
    tick();
    bus2.mem_read_ready = 2'b00;
    check("t4_c2c3_ready", {bus2.consumer_read_ready, bus2.consumer_read_data[2], bus2.consumer_read_data[3]},
          {4'b1100, 32'hC2, 32'hD3});
    bus2.consumer_read_valid[2] = 1'b0;
    bus2.consumer_read_valid[3] = 1'b0;
    tick();
    check("t4_done", {bus2.consumer_read_ready, bus2.mem_read_valid}, 64'd0);

    // Reset while a read is outstanding; late memory ready must be ignored.
    do_reset();
    bus1.consumer_read_valid[0]   = 1'b1;
    bus1.consumer_read_address[0] = 32'h50;
    tick();
    check("t5_issue", 64'(bus1.mem_read_valid[0]), 64'd1);
    reset = 1'b1;
    bus1.consumer_read_valid[0] = 1'b0;
    tick();
    check("t5_rst_out", {bus1.mem_read_valid, bus1.mem_read_address[0], bus1.consumer_read_ready}, 64'd0);
    reset = 1'b0;
    bus1.mem_read_ready[0] = 1'b1;
    bus1.mem_read_data[0]  = 32'hBAD;
    tick();
    bus1.mem_read_ready[0] = 1'b0;
    tick();
    check("t5_late_ready", {bus1.consumer_read_ready, bus1.mem_read_valid}, 64'd0);

    // Write with memory holding off for 5 cycles.
    do_reset();
    bus1.consumer_write_valid[0]   = 1'b1;
    bus1.consumer_write_address[0] = 32'h40;
    bus1.consumer_write_data[0]    = 32'h7;
    tick();
    check("t6_issue", {bus1.mem_write_valid[0], bus1.mem_write_address[0], bus1.mem_write_data[0]},
          {1'b1, 32'h40, 32'h7});
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_stable", {bus1.mem_write_valid[0], bus1.mem_write_address[0], bus1.mem_write_data[0],
            bus1.consumer_write_ready}, {1'b1, 32'h40, 32'h7, 4'b0000});
    end
    serve_write(0, 32'h40, 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
